// File: rtl/mem_wb_stage_pkg.sv
// Shared types and defaults for the MEM/WB stage: FSM encoding and datapath widths.
package mem_wb_stage_pkg;

  localparam int DATA_SIZE   = 32;
  localparam int PC_SIZE     = 18;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Load extension, combinational: word passes through, halfword picks a lane by
// address bit 1 and sign- or zero-extends it.
module mem_wb_stage_load_ext
  import mem_wb_stage_pkg::*;
#(
  parameter int data_size = DATA_SIZE
) (
  input  logic [data_size-1:0] rdata_q,
  input  logic                 addr_bit1,
  input  logic                 SignextendLoad,
  input  logic                 Signextend,
  output logic [data_size-1:0] ext_data
);

  logic [15:0] half;

  always_comb begin
    half     = addr_bit1 ? rdata_q[31:16] : rdata_q[15:0];
    ext_data = rdata_q;
    if (SignextendLoad) begin
      ext_data = {{(data_size-16){Signextend & half[15]}}, half};
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB register: 1 falling edge for non-memory ops, 3 + ack-wait edges for memory ops;
// stall holds upstream until the access completes. Optional access watchdog: MEM_TIMEOUT_EN.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int pc_size   = PC_SIZE,
  parameter int data_size = DATA_SIZE,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 M_MemtoReg,
  input  logic                 M_RegWrite,
  input  logic                 M_MemWrite,
  input  logic                 M_Jal,
  input  logic                 M_SignextendLoad,
  input  logic                 M_Signextend,
  input  logic [data_size-1:0] M_ALU_result,
  input  logic [data_size-1:0] M_Rt_data,
  input  logic [pc_size-1:0]   M_PCplus8,
  input  logic [4:0]           M_WR_out,
  output logic                 DM_req,
  output logic                 DM_we,
  output logic [data_size-1:0] DM_addr,
  output logic [data_size-1:0] DM_wdata,
  input  logic [data_size-1:0] DM_rdata,
  input  logic                 DM_ack,
  output logic                 stall,
  output logic                 WB_RegWrite,
  output logic [4:0]           WB_WR_out,
  output logic [data_size-1:0] WB_WD,
  output logic                 mem_err
);

  state_t                 state, state_nxt;
  logic                   mem_op;
  logic                   capture;
  logic                   timeout_hit;
  logic                   wr_block;
  logic [data_size-1:0]   rdata_q;
  logic [data_size-1:0]   load_data;
  logic [data_size-1:0]   wd_nxt;

  assign mem_op = M_MemtoReg | M_MemWrite;

`ifdef MEM_TIMEOUT_EN
  logic [3:0] cnt_q;
  logic       timed_out_q;
  logic       mem_err_q;

  assign timeout_hit = (state == WAIT) && !DM_ack && (cnt_q == 4'(TIMEOUT - 1));
  assign wr_block    = timed_out_q && (state == DONE);
  assign mem_err     = mem_err_q;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      if (state != WAIT) cnt_q <= '0;
      else               cnt_q <= cnt_q + 4'd1;
      timed_out_q <= timeout_hit;
      if (timeout_hit) mem_err_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign wr_block    = 1'b0;
  assign mem_err     = 1'b0;
  assign unused_cfg  = (TIMEOUT != 0);
`endif

  always_ff @(negedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_op) state_nxt = WAIT;
      WAIT:    if (DM_ack || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    DM_req   = (state == WAIT);
    DM_we    = DM_req & M_MemWrite;
    DM_addr  = DM_req ? M_ALU_result : '0;
    DM_wdata = DM_req ? M_Rt_data : '0;
    stall    = (state == WAIT) || ((state == IDLE) && mem_op);
    capture  = (state == DONE) || ((state == IDLE) && !mem_op);
  end

  mem_wb_stage_load_ext #(.data_size(data_size)) load_ext (
    .rdata_q        (rdata_q),
    .addr_bit1      (M_ALU_result[1]),
    .SignextendLoad (M_SignextendLoad),
    .Signextend     (M_Signextend),
    .ext_data       (load_data)
  );

  always_comb begin
    if (M_Jal)           wd_nxt = {{(data_size-pc_size){1'b0}}, M_PCplus8};
    else if (M_MemtoReg) wd_nxt = load_data;
    else                 wd_nxt = M_ALU_result;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if ((state == WAIT) && DM_ack) begin
      rdata_q <= DM_rdata;
    end
  end

  // Anything other than a capture cycle pushes a bubble into write-back.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      WB_RegWrite <= 1'b0;
      WB_WR_out   <= '0;
      WB_WD       <= '0;
    end else if (capture) begin
      WB_RegWrite <= M_RegWrite & ~wr_block;
      WB_WR_out   <= M_WR_out;
      WB_WD       <= wd_nxt;
    end else begin
      WB_RegWrite <= 1'b0;
      WB_WR_out   <= '0;
      WB_WD       <= '0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU, jal, loads (word/half, sign/zero), store with ack delay,
// stray ack, reset mid-access, and the watchdog path when MEM_TIMEOUT_EN is defined.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        M_MemtoReg, M_RegWrite, M_MemWrite, M_Jal;
  logic        M_SignextendLoad, M_Signextend;
  logic [31:0] M_ALU_result, M_Rt_data;
  logic [17:0] M_PCplus8;
  logic [4:0]  M_WR_out;
  logic        DM_req, DM_we;
  logic [31:0] DM_addr, DM_wdata, DM_rdata;
  logic        DM_ack;
  logic        stall;
  logic        WB_RegWrite;
  logic [4:0]  WB_WR_out;
  logic [31:0] WB_WD;
  logic        mem_err;

  int checks = 0;
  int errors = 0;
  int st, rq;

  mem_wb_stage dut (
    .clk              (clk),
    .rst              (rst),
    .M_MemtoReg       (M_MemtoReg),
    .M_RegWrite       (M_RegWrite),
    .M_MemWrite       (M_MemWrite),
    .M_Jal            (M_Jal),
    .M_SignextendLoad (M_SignextendLoad),
    .M_Signextend     (M_Signextend),
    .M_ALU_result     (M_ALU_result),
    .M_Rt_data        (M_Rt_data),
    .M_PCplus8        (M_PCplus8),
    .M_WR_out         (M_WR_out),
    .DM_req           (DM_req),
    .DM_we            (DM_we),
    .DM_addr          (DM_addr),
    .DM_wdata         (DM_wdata),
    .DM_rdata         (DM_rdata),
    .DM_ack           (DM_ack),
    .stall            (stall),
    .WB_RegWrite      (WB_RegWrite),
    .WB_WR_out        (WB_WR_out),
    .WB_WD            (WB_WD),
    .mem_err          (mem_err)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_instr(input logic mtr, input logic rw, input logic mw, input logic jal,
                           input logic hw, input logic sx, input logic [31:0] alu,
                           input logic [31:0] rt, input logic [17:0] pc8, input logic [4:0] wr);
    M_MemtoReg = mtr; M_RegWrite = rw; M_MemWrite = mw; M_Jal = jal;
    M_SignextendLoad = hw; M_Signextend = sx;
    M_ALU_result = alu; M_Rt_data = rt; M_PCplus8 = pc8; M_WR_out = wr;
    #1;
  endtask

  // Drives one memory op from IDLE to write-back; ack arrives after 'extra' idle WAIT cycles.
  task automatic run_mem(input int extra, input logic [31:0] rd, output int st_c, output int rq_c);
    st_c = 0; rq_c = 0;
    if (stall) st_c++;
    if (DM_req) rq_c++;
    tick();
    check("wait_bubble_rw", 32'(WB_RegWrite), 32'd0);
    for (int i = 0; i <= extra; i++) begin
      if (stall) st_c++;
      if (DM_req) rq_c++;
      check("dm_addr", DM_addr, M_ALU_result);
      check("dm_wdata", DM_wdata, M_Rt_data);
      check("dm_we", 32'(DM_we), 32'(M_MemWrite));
      if (i == extra) begin
        DM_ack = 1'b1; DM_rdata = rd;
      end
      tick();
    end
    DM_ack = 1'b0; DM_rdata = 32'h0;
    #1;
    if (stall) st_c++;
    if (DM_req) rq_c++;
    check("done_addr_zero", DM_addr, 32'h0);
    tick();
  endtask

  initial begin
    rst = 1'b1; DM_ack = 1'b0; DM_rdata = 32'h0;
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 18'h0, 5'd0);
    tick();
    tick();
    check("rst_wb_rw", 32'(WB_RegWrite), 32'd0);
    check("rst_wb_wr", 32'(WB_WR_out), 32'd0);
    check("rst_wb_wd", WB_WD, 32'h0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_dm_req", 32'(DM_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    // ALU op: single edge to write-back, no stall
    set_instr(0, 1, 0, 0, 0, 0, 32'h1234, 32'h0, 18'h0, 5'd5);
    check("alu_stall", 32'(stall), 32'd0);
    tick();
    check("alu_rw", 32'(WB_RegWrite), 32'd1);
    check("alu_wr", 32'(WB_WR_out), 32'd5);
    check("alu_wd", WB_WD, 32'h1234);

    // lw, ack on first WAIT cycle
    set_instr(1, 1, 0, 0, 0, 0, 32'h100, 32'h0, 18'h0, 5'd7);
    run_mem(0, 32'hDEADBEEF, st, rq);
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 18'h0, 5'd0);
    check("lw_stall_cycles", 32'(st), 32'd2);
    check("lw_req_cycles", 32'(rq), 32'd1);
    check("lw_rw", 32'(WB_RegWrite), 32'd1);
    check("lw_wr", 32'(WB_WR_out), 32'd7);
    check("lw_wd", WB_WD, 32'hDEADBEEF);

    // lh upper lane, sign-extend
    set_instr(1, 1, 0, 0, 1, 1, 32'h102, 32'h0, 18'h0, 5'd8);
    run_mem(0, 32'h80010000, st, rq);
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 18'h0, 5'd0);
    check("lh_sx_wd", WB_WD, 32'hFFFF8001);

    // lh upper lane, zero-extend
    set_instr(1, 1, 0, 0, 1, 0, 32'h102, 32'h0, 18'h0, 5'd8);
    run_mem(0, 32'h80010000, st, rq);
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 18'h0, 5'd0);
    check("lh_zx_wd", WB_WD, 32'h00008001);

    // lh lower lane, sign-extend
    set_instr(1, 1, 0, 0, 1, 1, 32'h200, 32'h0, 18'h0, 5'd9);
    run_mem(0, 32'h12348765, st, rq);
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 18'h0, 5'd0);
    check("lh_lo_wd", WB_WD, 32'hFFFF8765);

    // sw, ack in the third WAIT cycle
    set_instr(0, 0, 1, 0, 0, 0, 32'h3C0, 32'hCAFEF00D, 18'h0, 5'd0);
    run_mem(2, 32'h0, st, rq);
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 18'h0, 5'd0);
    check("sw_stall_cycles", 32'(st), 32'd4);
    check("sw_req_cycles", 32'(rq), 32'd3);
    check("sw_rw", 32'(WB_RegWrite), 32'd0);
    check("sw_req_after", 32'(DM_req), 32'd0);

    // jal: link value zero-extended
    set_instr(0, 1, 0, 1, 0, 0, 32'hABCD, 32'h0, 18'h3FFF8, 5'd31);
    tick();
    check("jal_wd", WB_WD, 32'h0003FFF8);
    check("jal_wr", 32'(WB_WR_out), 32'd31);

    // stray ack in IDLE is ignored
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 18'h0, 5'd0);
    DM_ack = 1'b1; DM_rdata = 32'h55AA55AA;
    tick();
    DM_ack = 1'b0; DM_rdata = 32'h0;
    #1;
    check("stray_ack_req", 32'(DM_req), 32'd0);
    check("stray_ack_stall", 32'(stall), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // no ack: watchdog fires after TIMEOUT WAIT cycles
    set_instr(1, 1, 0, 0, 0, 0, 32'h400, 32'h0, 18'h0, 5'd3);
    tick();
    for (int i = 0; i < 14; i++) tick();
    check("to_req_last", 32'(DM_req), 32'd1);
    tick();
    check("to_req_drop", 32'(DM_req), 32'd0);
    check("to_mem_err", 32'(mem_err), 32'd1);
    tick();
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 18'h0, 5'd0);
    check("to_rw_forced", 32'(WB_RegWrite), 32'd0);
    tick();
    check("to_mem_err_sticky", 32'(mem_err), 32'd1);
`else
    // no ack: WAIT persists indefinitely, then completes normally
    set_instr(1, 1, 0, 0, 0, 0, 32'h400, 32'h0, 18'h0, 5'd3);
    tick();
    for (int i = 0; i < 20; i++) tick();
    check("nto_req_held", 32'(DM_req), 32'd1);
    check("nto_mem_err", 32'(mem_err), 32'd0);
    DM_ack = 1'b1; DM_rdata = 32'h0BADF00D;
    tick();
    DM_ack = 1'b0; DM_rdata = 32'h0;
    tick();
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 18'h0, 5'd0);
    check("nto_wd", WB_WD, 32'h0BADF00D);
`endif

    // reset during WAIT aborts the access
    set_instr(1, 1, 0, 0, 0, 0, 32'h500, 32'h0, 18'h0, 5'd4);
    tick();
    check("rw_pre_req", 32'(DM_req), 32'd1);
    #2;
    rst = 1'b1;
    set_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 18'h0, 5'd0);
    check("rw_req", 32'(DM_req), 32'd0);
    check("rw_stall", 32'(stall), 32'd0);
    check("rw_wb_rw", 32'(WB_RegWrite), 32'd0);
    check("rw_wb_wr", 32'(WB_WR_out), 32'd0);
    check("rw_wb_wd", WB_WD, 32'h0);
    check("rw_mem_err", 32'(mem_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_req", 32'(DM_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
